dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter for an RV64 core.
// Round-robin grant, legality check, one-cycle access, one-cycle response.
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 8192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [2:0]  funct3_0,
    input  logic [2:0]  funct3_1,
    input  logic [63:0] addr0,
    input  logic [63:0] addr1,
    input  logic [63:0] wdata0,
    input  logic [63:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rsp_valid0,
    output logic        rsp_valid1,
    output logic        rsp_err,
    output logic [63:0] rsp_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;

    // 1 means requester 1 was granted most recently
    logic        last_gnt;
    logic        win;
    logic        grant;

    logic        sel_we;
    logic [2:0]  sel_f3;
    logic [63:0] sel_addr;
    logic [63:0] sel_wdata;
    logic        sel_bad;

    logic        l_we;
    logic [2:0]  l_f3;
    logic [63:0] l_addr;
    logic [63:0] l_wdata;
    logic        l_id;
    logic        l_err;
    logic [63:0] rsp_data;

    // End address is computed in 65 bits so addresses near 2^64 cannot wrap
    function automatic logic illegal_req(
        input logic        we,
        input logic [2:0]  f3,
        input logic [63:0] addr
    );
        logic [3:0]  size;
        logic [2:0]  mask;
        logic [64:0] last;
        logic        bad;
        size = 4'd1 << f3[1:0];
        mask = size[2:0] - 3'd1;
        last = {1'b0, addr} + {61'd0, size};
        bad  = 1'b0;
        if (we && f3[2])
            bad = 1'b1;
        if (!we && (f3 == 3'b111))
            bad = 1'b1;
        if ((addr[2:0] & mask) != 3'd0)
            bad = 1'b1;
        if (last > 65'(MEM_BYTES))
            bad = 1'b1;
        return bad;
    endfunction

    // Round-robin winner: lone requester wins, ties go to the one not served last
    always_comb begin
        win = 1'b0;
        if (req0 && req1)
            win = ~last_gnt;
        else
            win = req1;
    end

    // Winner's request fields and their legality
    always_comb begin
        sel_we    = win ? we1 : we0;
        sel_f3    = win ? funct3_1 : funct3_0;
        sel_addr  = win ? addr1 : addr0;
        sel_wdata = win ? wdata1 : wdata0;
        sel_bad   = illegal_req(sel_we, sel_f3, sel_addr);
    end

    // Next state and grants; grants only leave IDLE
    always_comb begin
        state_nx = state;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        unique case (state)
            IDLE: begin
                if (rst_n && (req0 || req1)) begin
                    gnt0     = ~win;
                    gnt1     = win;
                    state_nx = sel_bad ? RESP : ACCESS;
                end
            end
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign grant = gnt0 | gnt1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Latch the winning request on its grant cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
            l_we     <= 1'b0;
            l_f3     <= 3'd0;
            l_addr   <= 64'd0;
            l_wdata  <= 64'd0;
            l_id     <= 1'b0;
            l_err    <= 1'b0;
        end else if (grant) begin
            last_gnt <= win;
            l_we     <= sel_we;
            l_f3     <= sel_f3;
            l_addr   <= sel_addr;
            l_wdata  <= sel_wdata;
            l_id     <= win;
            l_err    <= sel_bad;
        end
    end

    // Response data: cleared at grant, loaded from memory at end of a load access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rsp_data <= 64'd0;
        else if (grant)
            rsp_data <= 64'd0;
        else if ((state == ACCESS) && !l_we)
            rsp_data <= mem_rdata;
    end

    // Memory and response outputs, forced to zero while reset is low
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_funct3 = 3'd0;
        mem_addr   = 64'd0;
        mem_wdata  = 64'd0;
        rsp_valid0 = 1'b0;
        rsp_valid1 = 1'b0;
        rsp_err    = 1'b0;
        rsp_rdata  = 64'd0;
        if (rst_n && (state == ACCESS)) begin
            mem_read   = ~l_we;
            mem_write  = l_we;
            mem_funct3 = l_f3;
            mem_addr   = l_addr;
            mem_wdata  = l_wdata;
        end
        if (rst_n && (state == RESP)) begin
            rsp_valid0 = ~l_id;
            rsp_valid1 = l_id;
            rsp_err    = l_err;
            rsp_rdata  = (l_err || l_we) ? 64'd0 : rsp_data;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter.
// Byte-array memory environment plus a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int MEMB = 8192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [2:0]  funct3_0, funct3_1;
    logic [63:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err;
    logic [63:0] rsp_rdata;
    logic        mem_read, mem_write;
    logic [2:0]  mem_funct3;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    int vecs = 0;
    int miscmp = 0;

    dmem_arbiter #(.MEM_BYTES(MEMB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .funct3_0(funct3_0), .funct3_1(funct3_1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_funct3(mem_funct3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- memory environment ----------------
    logic [7:0]  mem [MEMB];
    logic [63:0] mem_raw;
    logic        mem_clear;

    function automatic logic [63:0] ext(input logic [63:0] r, input logic [2:0] f3);
        case (f3)
            3'b000:  return {{56{r[7]}}, r[7:0]};
            3'b001:  return {{48{r[15]}}, r[15:0]};
            3'b010:  return {{32{r[31]}}, r[31:0]};
            3'b011:  return r;
            3'b100:  return {56'd0, r[7:0]};
            3'b101:  return {48'd0, r[15:0]};
            3'b110:  return {32'd0, r[31:0]};
            default: return 64'd0;
        endcase
    endfunction

    always_comb begin
        mem_raw = '0;
        for (int i = 0; i < 8; i++)
            mem_raw[i*8 +: 8] = mem[(int'(mem_addr[12:0]) + i) % MEMB];
        mem_rdata = mem_read ? ext(mem_raw, mem_funct3) : 64'd0;
    end

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < MEMB; i++)
                mem[i] <= 8'h00;
        end else if (mem_write) begin
            for (int i = 0; i < (1 << mem_funct3[1:0]); i++)
                mem[(int'(mem_addr[12:0]) + i) % MEMB] <= mem_wdata[i*8 +: 8];
        end
    end

    // Access monitor
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [63:0] acc_addr = 0;
    logic [2:0]  acc_f3 = 0;
    logic [63:0] acc_wd = 0;

    always @(negedge clk) begin
        if (mem_write) wr_cnt++;
        if (mem_read) rd_cnt++;
        if (mem_write || mem_read) begin
            acc_addr = mem_addr;
            acc_f3   = mem_funct3;
            acc_wd   = mem_wdata;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [MEMB];

    function automatic bit ref_illegal(input bit we, input logic [2:0] f3, input logic [63:0] addr);
        logic [63:0] sz;
        sz = 64'd1 << f3[1:0];
        return (we && f3 >= 3'd4) || (!we && f3 == 3'd7) ||
               (addr % sz != 0) || (addr > 64'(MEMB) - sz);
    endfunction

    function automatic logic [63:0] ref_load(input logic [63:0] addr, input logic [2:0] f3);
        int          sz;
        logic [63:0] v;
        sz = 1 << f3[1:0];
        v  = 0;
        for (int i = 0; i < sz; i++)
            v = v | (64'(ref_mem[int'(addr[12:0]) + i]) << (8 * i));
        if (f3 < 3'd4 && sz < 8 && v[8*sz-1])
            v = v - (64'd1 << (8 * sz));
        return v;
    endfunction

    task automatic ref_store(input logic [63:0] addr, input logic [2:0] f3, input logic [63:0] wd);
        for (int i = 0; i < (1 << f3[1:0]); i++)
            ref_mem[int'(addr[12:0]) + i] = wd[i*8 +: 8];
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit id, input bit r, input bit we, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd);
        if (!id) begin
            req0 = r; we0 = we; funct3_0 = f3; addr0 = a; wdata0 = wd;
        end else begin
            req1 = r; we1 = we; funct3_1 = f3; addr1 = a; wdata1 = wd;
        end
    endtask

    task automatic scramble(input bit id);
        drive(id, 1'b0, 1'($urandom), 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    // One complete single-requester transaction with full checking
    task automatic txn(input bit id, input bit we, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd, input string nm);
        bit          ill;
        logic [63:0] exp_d;
        logic [1:0]  g, rv, exp_rv;
        logic        er;
        logic [63:0] rd;
        int          w0, r0, lat, exp_lat;
        ill     = ref_illegal(we, f3, a);
        exp_d   = (ill || we) ? 64'd0 : ref_load(a, f3);
        exp_lat = ill ? 1 : 2;
        exp_rv  = id ? 2'b10 : 2'b01;
        @(negedge clk);
        drive(id, 1'b1, we, f3, a, wd);
        #1;
        g = {gnt1, gnt0};
        vecs++;
        if (g !== exp_rv) begin
            miscmp++;
            $display("FAIL %s gnt: got %b want %b", nm, g, exp_rv);
        end
        w0 = wr_cnt;
        r0 = rd_cnt;
        @(posedge clk);
        #1;
        scramble(id);
        lat = 0; rv = 0; er = 0; rd = 0;
        for (int c = 1; c <= 5 && lat == 0; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid0 || rsp_valid1) begin
                lat = c;
                rv  = {rsp_valid1, rsp_valid0};
                er  = rsp_err;
                rd  = rsp_rdata;
            end
        end
        vecs++;
        if (lat !== exp_lat) begin
            miscmp++;
            $display("FAIL %s latency: got %0d want %0d (0 = timeout)", nm, lat, exp_lat);
        end
        vecs++;
        if (rv !== exp_rv) begin
            miscmp++;
            $display("FAIL %s rsp_valid: got %b want %b", nm, rv, exp_rv);
        end
        vecs++;
        if (er !== ill) begin
            miscmp++;
            $display("FAIL %s rsp_err: got %b want %b", nm, er, ill);
        end
        vecs++;
        if (rd !== exp_d) begin
            miscmp++;
            $display("FAIL %s rsp_rdata: got %h want %h", nm, rd, exp_d);
        end
        vecs++;
        if ((wr_cnt - w0) !== int'(!ill && we) || (rd_cnt - r0) !== int'(!ill && !we)) begin
            miscmp++;
            $display("FAIL %s mem access count: wr %0d rd %0d want wr %0d rd %0d",
                     nm, wr_cnt - w0, rd_cnt - r0, int'(!ill && we), int'(!ill && !we));
        end
        if (!ill) begin
            vecs++;
            if ({acc_f3, acc_addr} !== {f3, a} || (we && acc_wd !== wd)) begin
                miscmp++;
                $display("FAIL %s mem fields: got f3 %0d addr %h wd %h want f3 %0d addr %h wd %h",
                         nm, acc_f3, acc_addr, acc_wd, f3, a, wd);
            end
        end
        if (!ill && we)
            ref_store(a, f3, wd);
    endtask

    task automatic check_quiet(input string nm);
        logic [265:0] o;
        o = {gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err, rsp_rdata,
             mem_read, mem_write, mem_funct3, mem_addr, mem_wdata};
        vecs++;
        if (o !== '0) begin
            miscmp++;
            $display("FAIL %s outputs: got %h want 0", nm, o);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        drive(0, 1'b1, 1'b0, 3'b011, 64'h10, 64'h0);
        drive(1, 1'b1, 1'b0, 3'b011, 64'h18, 64'h0);
        #1;
        check_quiet("reset_a");
        @(negedge clk);
        check_quiet("reset_b");
    endtask

    task automatic test_rr;
        int gid[$], gcy[$], vid[$], vcy[$];
        logic [63:0] rdv[$];
        int want[4];
        want = '{0, 1, 0, 1};
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 40 && gid.size() < 4; cyc++) begin
            #1;
            if (gnt0 && gnt1) begin
                vecs++;
                miscmp++;
                $display("FAIL rr double grant at cycle %0d", cyc);
            end
            if (gnt0 || gnt1) begin
                gid.push_back(gnt1 ? 1 : 0);
                gcy.push_back(cyc);
            end
            if (rsp_valid0 || rsp_valid1) begin
                vid.push_back(rsp_valid1 ? 1 : 0);
                vcy.push_back(cyc);
                rdv.push_back(rsp_rdata);
            end
            if (gid.size() < 4)
                @(negedge clk);
        end
        @(posedge clk);
        #1;
        scramble(0);
        scramble(1);
        repeat (3) @(negedge clk);
        vecs++;
        if (gid.size() != 4) begin
            miscmp++;
            $display("FAIL rr grant count: got %0d want 4", gid.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vecs++;
                if (gid[i] !== want[i]) begin
                    miscmp++;
                    $display("FAIL rr order[%0d]: got %0d want %0d", i, gid[i], want[i]);
                end
            end
            vecs++;
            if (gcy[0] !== 0) begin
                miscmp++;
                $display("FAIL rr first gnt cycle: got %0d want 0", gcy[0]);
            end
            for (int i = 1; i < 4; i++) begin
                vecs++;
                if (gcy[i] - gcy[i-1] !== 3) begin
                    miscmp++;
                    $display("FAIL rr gnt gap[%0d]: got %0d want 3", i, gcy[i] - gcy[i-1]);
                end
            end
        end
        vecs++;
        if (vid.size() < 3 || vid[0] !== 0 || vcy[0] !== 2 || vid[1] !== 1 || vcy[1] !== 5) begin
            miscmp++;
            $display("FAIL rr rsp timing: got %0d responses, first id/cycle %0d/%0d want 0/2 then 1/5",
                     vid.size(), vid.size() > 0 ? vid[0] : -1, vcy.size() > 0 ? vcy[0] : -1);
        end
        vecs++;
        if (rdv.size() < 1 || rdv[0] !== ref_load(64'h10, 3'b011)) begin
            miscmp++;
            $display("FAIL rr rsp_rdata: got %h want %h",
                     rdv.size() > 0 ? rdv[0] : 64'hx, ref_load(64'h10, 3'b011));
        end
    endtask

    task automatic test_store_load;
        txn(0, 1, 3'b011, 64'h40, 64'h1122334455667788, "sd_0x40");
        txn(0, 0, 3'b011, 64'h40, 64'h0, "ld_0x40");
        txn(1, 0, 3'b000, 64'h47, 64'h0, "lb_0x47");
        txn(1, 0, 3'b110, 64'h44, 64'h0, "lwu_0x44");
    endtask

    task automatic test_misaligned;
        txn(1, 1, 3'b010, 64'h42, 64'hDEADBEEFCAFEF00D, "sw_0x42");
        txn(0, 0, 3'b111, 64'h40, 64'h0, "ld_f3_111");
    endtask

    task automatic test_boundary;
        txn(0, 1, 3'b000, 64'h1FFF, 64'h85, "sb_0x1fff");
        txn(0, 0, 3'b000, 64'h1FFF, 64'h0, "lb_0x1fff");
        txn(0, 0, 3'b001, 64'h1FFF, 64'h0, "lh_0x1fff");
        txn(0, 0, 3'b011, 64'hFFFFFFFFFFFFFFF8, 64'h0, "ld_wrap");
        txn(0, 1, 3'b100, 64'h80, 64'h55, "st_f3_100");
        txn(1, 0, 3'b011, 64'h1FF8, 64'h0, "ld_0x1ff8");
        txn(1, 0, 3'b011, 64'h2000, 64'h0, "ld_0x2000");
    endtask

    task automatic test_random;
        for (int n = 0; n < 60; n++) begin
            bit          id, we;
            logic [2:0]  f3;
            logic [63:0] a;
            int          kind;
            id   = 1'($urandom);
            we   = 1'($urandom);
            f3   = 3'($urandom);
            kind = $urandom_range(0, 4);
            case (kind)
                0, 1:    a = (64'h100 + 64'($urandom_range(0, 63))) & ~64'((1 << f3[1:0]) - 1);
                2:       a = 64'h100 + 64'($urandom_range(0, 63));
                3:       a = 64'(MEMB) - 64'($urandom_range(1, 16));
                default: a = {$urandom, $urandom};
            endcase
            txn(id, we, f3, a, {$urandom, $urandom}, $sformatf("rand%0d", n));
        end
    endtask

    task automatic test_reset_mid;
        logic [1:0] g;
        int         seen;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 3'b011, 64'h80, 64'hA5A5A5A5A5A5A5A5);
        #1;
        vecs++;
        if (gnt0 !== 1'b1) begin
            miscmp++;
            $display("FAIL rmid gnt0: got %b want 1", gnt0);
        end
        @(posedge clk);
        #1;
        scramble(0);
        @(negedge clk);
        #1;
        vecs++;
        if (mem_write !== 1'b1) begin
            miscmp++;
            $display("FAIL rmid mem_write before reset: got %b want 1", mem_write);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_quiet("rmid_async");
        drive(0, 1'b1, 1'b0, 3'b011, 64'h80, 64'h0);
        drive(1, 1'b1, 1'b0, 3'b011, 64'h88, 64'h0);
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            #1;
            if (rsp_valid0 || rsp_valid1 || gnt0 || gnt1) seen++;
        end
        vecs++;
        if (seen !== 0) begin
            miscmp++;
            $display("FAIL rmid activity in reset: got %0d cycles want 0", seen);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        g = {gnt1, gnt0};
        vecs++;
        if (g !== 2'b01) begin
            miscmp++;
            $display("FAIL rmid tie after reset: got %b want 01", g);
        end
        @(posedge clk);
        #1;
        scramble(0);
        scramble(1);
        repeat (3) @(negedge clk);
        txn(1, 0, 3'b011, 64'h80, 64'h0, "rmid_ld_0x80");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < MEMB; i++)
            ref_mem[i] = 8'h00;
        rst_n     = 1'b0;
        mem_clear = 1'b1;
        scramble(0);
        scramble(1);
        repeat (2) @(posedge clk);
        #1;
        mem_clear = 1'b0;
        test_reset;
        test_rr;
        test_store_load;
        test_misaligned;
        test_boundary;
        test_random;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule
